cp0_regfile: RTL and testbench
==============================

Name: cp0_regfile

Overview:
- Stateful coprocessor-0 register file for the MIPS core.
- Holds BadVAddr, Count, Compare, Status, Cause, EPC and ErrorEPC.
- Applies MTC0 writes through per-register write masks, runs the Count/Compare timer and records exception state.
- Produces the interrupt request consumed by the exception unit in the writeback/commit stage.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt lines, legal range 1..6; mapped to Cause.IP[2+i]
COUNT_DIV, 2, clock cycles per Count increment, legal range >=1
STATUS_RESET, 32'h0040_0000, Status value loaded at reset (BEV=1)

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
mtc0_en  in  1  MTC0 commit strobe
mtc0_addr  in  5  destination CP0 register number
mtc0_data  in  32  value written
mfc0_addr  in  5  read register number
mfc0_data  out  32  combinational read of current state, no same-cycle write bypass
exc_valid  in  1  exception taken this cycle
exc_code  in  5  ExcCode to record
exc_pc  in  32  PC of faulting instruction
exc_in_delay  in  1  faulting instruction sits in a branch delay slot
exc_badvaddr_valid  in  1  BadVAddr must be updated
exc_badvaddr  in  32  faulting address
eret  in  1  ERET commit strobe
hw_int  in  NUM_HW_INT  level-sensitive external interrupts
epc  out  32  current EPC (ERET target)
status  out  32  current Status
cause  out  32  current Cause
int_req  out  1  interrupt pending and enabled

Behaviour:
- Reset (synchronous):
  - Status = STATUS_RESET.
  - All other registers = 0: Cause, Count, Compare, EPC, BadVAddr, ErrorEPC.
  - Divider phase = 0.
- Write masks:
  - Status 32'h0000_FF03 (IM, EXL, IE).
  - Cause 32'h0000_0300 (IP1..0).
  - Count, Compare, EPC and ErrorEPC are fully writable.
  - BadVAddr is read-only to software.
  - Unimplemented addresses: writes ignored, reads return 0.
- Masked write rule: new = (old & ~mask) | (mtc0_data & mask). Takes effect next cycle.
- Count:
  - Divider phase counts 0..COUNT_DIV-1. Count increments by 1 in the cycle the phase reaches COUNT_DIV-1.
  - Count wraps 32'hFFFF_FFFF -> 0.
  - MTC0 to Count loads mtc0_data, clears the phase, and suppresses that cycle's increment.
- Timer interrupt:
  - Cause.TI (bit 30) sets on an increment whose result equals Compare.
  - TI stays set until an MTC0 to Compare, which clears TI and loads Compare.
  - A write to Compare that equals the current Count does not set TI.
- Hardware interrupts:
  - Cause.IP[2+i] is registered from hw_int[i] every cycle (one-cycle latency); unused IP bits read 0.
  - Cause.IP[7] additionally ORs in TI.
- int_req (combinational from registers) = Status.IE & ~Status.EXL & |(Cause.IP[7:0] & Status.IM[7:0]).
- Exception (exc_valid=1):
  - If Status.EXL=0: EPC = exc_in_delay ? exc_pc-4 : exc_pc, and Cause.BD = exc_in_delay.
  - If Status.EXL=1: EPC and BD are unchanged.
  - Always: Cause.ExcCode = exc_code, Status.EXL = 1.
  - If exc_badvaddr_valid: BadVAddr = exc_badvaddr.
- ERET: Status.EXL cleared next cycle.
- Same-cycle conflicts:
  - exc_valid blocks both mtc0_en and eret; neither has any effect.
  - eret with mtc0_en: the MTC0 write applies, but EXL ends 0 regardless of written data.
  - Timer increment and IP sampling run every cycle irrespective of exceptions or writes.
  - MTC0 to Cause cannot clear TI or hardware IP bits.
- Reset asserted mid-operation overrides all strobes in that cycle.

Test Plan:
- Reset, then read every address 0..31 -> Status=32'h0040_0000; all implemented others 0; unimplemented 0; int_req=0.
- COUNT_DIV=2, no writes, run 10 cycles -> Count=5. MTC0 Count=32'hFFFF_FFFF, then 2 cycles -> Count=0 (wrap).
- Compare=20, Count=18, Status=32'h0000_8001 -> TI and Cause.IP7 set on increment to 20, int_req=1. MTC0 Compare=100 -> TI=0, int_req=0 next cycle.
- MTC0 Status=32'hFFFF_FFFF -> reads 32'h0040_FF03. MTC0 Cause=32'hFFFF_FFFF -> only IP1..0 set. MTC0 BadVAddr=1 -> BadVAddr stays 0.
- exc_valid, code 5'h04, pc=32'hBFC0_0104, in_delay=1, badvaddr=32'h1 -> EPC=32'hBFC0_0100, BD=1, EXL=1, BadVAddr=1. Second exception with code 5'h0C -> EPC and BD unchanged, ExcCode=5'h0C. eret -> EXL=0.
- exc_valid with mtc0_en (EPC=32'h1234) and eret in the same cycle -> EPC from exception, EXL=1. hw_int[0]=1 with IM2 and IE set, EXL=0 -> Cause.IP2=1 and int_req=1 one cycle later.

Source files
------------

// File: rtl/cp0_regfile.sv
// cp0_regfile: coprocessor-0 register file for the MIPS core.
// Holds BadVAddr(8), Count(9), Compare(11), Status(12), Cause(13), EPC(14)
// and ErrorEPC(30). Applies masked MTC0 writes, runs the Count/Compare timer,
// records exception state and raises the interrupt request.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   mtc0_en/addr/data   MTC0 commit strobe, register number, write value
//   mfc0_addr/data      combinational register read (no write bypass)
//   exc_*               exception taken this cycle and its recorded state
//   eret                ERET commit strobe (clears Status.EXL)
//   hw_int              level-sensitive hardware interrupt lines
//   epc/status/cause    current register values
//   int_req             enabled interrupt pending
module cp0_regfile #(
  parameter int unsigned NUM_HW_INT   = 6,
  parameter int unsigned COUNT_DIV    = 2,
  parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mtc0_en,
  input  logic [4:0]            mtc0_addr,
  input  logic [31:0]           mtc0_data,
  input  logic [4:0]            mfc0_addr,
  output logic [31:0]           mfc0_data,
  input  logic                  exc_valid,
  input  logic [4:0]            exc_code,
  input  logic [31:0]           exc_pc,
  input  logic                  exc_in_delay,
  input  logic                  exc_badvaddr_valid,
  input  logic [31:0]           exc_badvaddr,
  input  logic                  eret,
  input  logic [NUM_HW_INT-1:0] hw_int,
  output logic [31:0]           epc,
  output logic [31:0]           status,
  output logic [31:0]           cause,
  output logic                  int_req
);

  localparam logic [4:0] AddrBadVAddr = 5'd8;
  localparam logic [4:0] AddrCount    = 5'd9;
  localparam logic [4:0] AddrCompare  = 5'd11;
  localparam logic [4:0] AddrStatus   = 5'd12;
  localparam logic [4:0] AddrCause    = 5'd13;
  localparam logic [4:0] AddrEpc      = 5'd14;
  localparam logic [4:0] AddrErrorEpc = 5'd30;

  localparam logic [31:0] StatusMask = 32'h0000_FF03;

  localparam int unsigned PhaseW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(COUNT_DIV - 1);

  logic [31:0]       badvaddr_q, badvaddr_d;
  logic [31:0]       count_q, count_d;
  logic [31:0]       compare_q, compare_d;
  logic [31:0]       status_q, status_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       errorepc_q, errorepc_d;
  logic              bd_q, bd_d;
  logic              ti_q, ti_d;
  logic [1:0]        ip_sw_q, ip_sw_d;
  logic [5:0]        ip_hw_q, ip_hw_d;
  logic [4:0]        exc_code_q, exc_code_d;
  logic [PhaseW-1:0] phase_q, phase_d;

  logic        wr_en;
  logic        eret_en;
  logic [31:0] count_inc;
  logic [7:0]  ip_all;
  logic [31:0] cause_val;

  // IP7 is shared between the top hardware line and the timer.
  assign ip_all    = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
  assign cause_val = {bd_q, ti_q, 14'b0, ip_all, 1'b0, exc_code_q, 2'b0};
  assign count_inc = count_q + 32'd1;

  // An exception in the same cycle squashes any MTC0 or ERET.
  assign wr_en   = mtc0_en & ~exc_valid;
  assign eret_en = eret & ~exc_valid;

  always_comb begin
    badvaddr_d = badvaddr_q;
    count_d    = count_q;
    compare_d  = compare_q;
    status_d   = status_q;
    epc_d      = epc_q;
    errorepc_d = errorepc_q;
    bd_d       = bd_q;
    ti_d       = ti_q;
    ip_sw_d    = ip_sw_q;
    ip_hw_d    = 6'(hw_int);
    exc_code_d = exc_code_q;
    phase_d    = phase_q;

    // Timer: a Count write reloads and restarts the divider, skipping the tick.
    if (wr_en && mtc0_addr == AddrCount) begin
      count_d = mtc0_data;
      phase_d = '0;
    end else if (phase_q == PhaseLast) begin
      phase_d = '0;
      count_d = count_inc;
      if (count_inc == compare_q) begin
        ti_d = 1'b1;
      end
    end else begin
      phase_d = phase_q + PhaseW'(1);
    end

    if (wr_en) begin
      case (mtc0_addr)
        AddrCompare: begin
          compare_d = mtc0_data;
          ti_d      = 1'b0; // clear wins over a same-cycle match
        end
        AddrStatus:   status_d   = (status_q & ~StatusMask) | (mtc0_data & StatusMask);
        AddrCause:    ip_sw_d    = mtc0_data[9:8];
        AddrEpc:      epc_d      = mtc0_data;
        AddrErrorEpc: errorepc_d = mtc0_data;
        default: ;
      endcase
    end

    if (eret_en) begin
      status_d[1] = 1'b0;
    end

    if (exc_valid) begin
      // Nested exceptions keep the original return point.
      if (!status_q[1]) begin
        epc_d = exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
        bd_d  = exc_in_delay;
      end
      exc_code_d  = exc_code;
      status_d[1] = 1'b1;
      if (exc_badvaddr_valid) begin
        badvaddr_d = exc_badvaddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      badvaddr_q <= '0;
      count_q    <= '0;
      compare_q  <= '0;
      status_q   <= STATUS_RESET;
      epc_q      <= '0;
      errorepc_q <= '0;
      bd_q       <= 1'b0;
      ti_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_hw_q    <= '0;
      exc_code_q <= '0;
      phase_q    <= '0;
    end else begin
      badvaddr_q <= badvaddr_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      epc_q      <= epc_d;
      errorepc_q <= errorepc_d;
      bd_q       <= bd_d;
      ti_q       <= ti_d;
      ip_sw_q    <= ip_sw_d;
      ip_hw_q    <= ip_hw_d;
      exc_code_q <= exc_code_d;
      phase_q    <= phase_d;
    end
  end

  always_comb begin
    mfc0_data = 32'b0;
    case (mfc0_addr)
      AddrBadVAddr: mfc0_data = badvaddr_q;
      AddrCount:    mfc0_data = count_q;
      AddrCompare:  mfc0_data = compare_q;
      AddrStatus:   mfc0_data = status_q;
      AddrCause:    mfc0_data = cause_val;
      AddrEpc:      mfc0_data = epc_q;
      AddrErrorEpc: mfc0_data = errorepc_q;
      default:      mfc0_data = 32'b0;
    endcase
  end

  assign epc     = epc_q;
  assign status  = status_q;
  assign cause   = cause_val;
  assign int_req = status_q[0] & ~status_q[1] & (|(ip_all & status_q[15:8]));

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: expected values are queued when the
// stimulus is applied and compared when the registers are read back.
module tb_cp0_regfile;

  logic        clk;
  logic        reset;
  logic        mtc0_en;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_data;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_data;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [31:0] exc_pc;
  logic        exc_in_delay;
  logic        exc_badvaddr_valid;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] epc;
  logic [31:0] status;
  logic [31:0] cause;
  logic        int_req;

  int n_checks = 0;
  int n_errors = 0;

  // kind: 0 = mfc0 read, 1 = int_req, 2 = epc port, 3 = status port, 4 = cause port
  typedef struct {
    string       tag;
    int          kind;
    logic [4:0]  addr;
    logic [31:0] exp;
  } sb_item_t;

  sb_item_t sb_q[$];

  cp0_regfile #(
    .NUM_HW_INT  (6),
    .COUNT_DIV   (2),
    .STATUS_RESET(32'h0040_0000)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .mtc0_en           (mtc0_en),
    .mtc0_addr         (mtc0_addr),
    .mtc0_data         (mtc0_data),
    .mfc0_addr         (mfc0_addr),
    .mfc0_data         (mfc0_data),
    .exc_valid         (exc_valid),
    .exc_code          (exc_code),
    .exc_pc            (exc_pc),
    .exc_in_delay      (exc_in_delay),
    .exc_badvaddr_valid(exc_badvaddr_valid),
    .exc_badvaddr      (exc_badvaddr),
    .eret              (eret),
    .hw_int            (hw_int),
    .epc               (epc),
    .status            (status),
    .cause             (cause),
    .int_req           (int_req)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_rd(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag; it.kind = 0; it.addr = addr; it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic exp_port(input string tag, input int kind, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag; it.kind = kind; it.addr = 5'd0; it.exp = exp;
    sb_q.push_back(it);
  endtask

  // Pops every queued expectation; each read takes 1 time unit, well inside
  // one clock phase, so no edge occurs while draining.
  task automatic drain();
    sb_item_t it;
    logic [31:0] got;
    while (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      mfc0_addr = it.addr;
      #1;
      case (it.kind)
        0:       got = mfc0_data;
        1:       got = {31'b0, int_req};
        2:       got = epc;
        3:       got = status;
        default: got = cause;
      endcase
      check(it.tag, got, it.exp);
    end
  endtask

  task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
    mtc0_en = 1'b1; mtc0_addr = addr; mtc0_data = data;
    tick();
    mtc0_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; mtc0_en = 1'b0; mtc0_addr = '0; mtc0_data = '0; mfc0_addr = '0;
    exc_valid = 1'b0; exc_code = '0; exc_pc = '0; exc_in_delay = 1'b0;
    exc_badvaddr_valid = 1'b0; exc_badvaddr = '0; eret = 1'b0; hw_int = '0;
    tick();
    tick();

    // Reset state, read while reset is still held.
    for (int a = 0; a < 32; a++) begin
      exp_rd($sformatf("reset_rd%0d", a), 5'(a), (a == 12) ? 32'h0040_0000 : 32'h0);
    end
    exp_port("reset_int_req", 1, 32'h0);
    drain();

    // Count divider and wrap.
    reset = 1'b0;
    repeat (10) tick();
    exp_rd("count_after10", 5'd9, 32'd5);
    drain();
    mtc0(5'd9, 32'hFFFF_FFFF);
    exp_rd("count_loaded", 5'd9, 32'hFFFF_FFFF);
    drain();
    tick();
    exp_rd("count_no_inc_yet", 5'd9, 32'hFFFF_FFFF);
    drain();
    tick();
    exp_rd("count_wrap", 5'd9, 32'h0);
    drain();

    // Timer interrupt.
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd20);
    mtc0(5'd9, 32'd18);
    repeat (3) tick();
    exp_rd("count_19", 5'd9, 32'd19);
    exp_port("ti_not_yet", 4, 32'h0);
    exp_port("int_req_not_yet", 1, 32'h0);
    drain();
    tick();
    exp_rd("count_20", 5'd9, 32'd20);
    exp_rd("cause_ti", 5'd13, 32'h4000_8000);
    exp_port("int_req_timer", 1, 32'h1);
    drain();
    mtc0(5'd11, 32'd100);
    exp_rd("compare_100", 5'd11, 32'd100);
    exp_port("cause_ti_clr", 4, 32'h0);
    exp_port("int_req_clr", 1, 32'h0);
    drain();

    // Compare written equal to current Count does not raise TI.
    mtc0(5'd9, 32'd50);
    mtc0(5'd11, 32'd50);
    exp_rd("cause_cmp_eq", 5'd13, 32'h0);
    drain();

    // Write masks.
    mtc0(5'd12, 32'hFFFF_FFFF);
    exp_rd("status_mask", 5'd12, 32'h0040_FF03);
    drain();
    mtc0(5'd13, 32'hFFFF_FFFF);
    exp_rd("cause_mask", 5'd13, 32'h0000_0300);
    exp_port("int_req_exl_blocks", 1, 32'h0);
    drain();
    mtc0(5'd8, 32'h1);
    exp_rd("badvaddr_ro", 5'd8, 32'h0);
    drain();
    mtc0(5'd5, 32'hFFFF_FFFF);
    exp_rd("unimpl_rd", 5'd5, 32'h0);
    drain();
    mtc0(5'd30, 32'hCAFE_F00D);
    exp_rd("errorepc", 5'd30, 32'hCAFE_F00D);
    drain();
    mtc0(5'd12, 32'h0);
    exp_port("status_clr", 3, 32'h0040_0000);
    drain();

    // Exception in a delay slot, then a nested one.
    exc_valid = 1'b1; exc_code = 5'h04; exc_pc = 32'hBFC0_0104; exc_in_delay = 1'b1;
    exc_badvaddr_valid = 1'b1; exc_badvaddr = 32'h1;
    tick();
    exp_port("exc1_epc", 2, 32'hBFC0_0100);
    exp_rd("exc1_cause", 5'd13, 32'h8000_0310);
    exp_rd("exc1_status", 5'd12, 32'h0040_0002);
    exp_rd("exc1_badvaddr", 5'd8, 32'h1);
    drain();
    exc_code = 5'h0C; exc_pc = 32'h0000_1000; exc_in_delay = 1'b0; exc_badvaddr_valid = 1'b0;
    tick();
    exp_rd("exc2_epc", 5'd14, 32'hBFC0_0100);
    exp_rd("exc2_cause", 5'd13, 32'h8000_0330);
    exp_rd("exc2_badvaddr", 5'd8, 32'h1);
    drain();
    exc_valid = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
    exp_rd("eret_status", 5'd12, 32'h0040_0000);
    drain();

    // Exception blocks a simultaneous MTC0 and ERET.
    exc_valid = 1'b1; exc_code = 5'h08; exc_pc = 32'h0000_2000; exc_in_delay = 1'b0;
    mtc0_en = 1'b1; mtc0_addr = 5'd14; mtc0_data = 32'h0000_1234; eret = 1'b1;
    tick();
    exc_valid = 1'b0; mtc0_en = 1'b0; eret = 1'b0;
    exp_rd("conflict_epc", 5'd14, 32'h0000_2000);
    exp_rd("conflict_status", 5'd12, 32'h0040_0002);
    exp_rd("conflict_cause", 5'd13, 32'h0000_0320);
    drain();

    // ERET with MTC0 Status: write applies but EXL ends clear.
    eret = 1'b1;
    mtc0(5'd12, 32'h0000_0403);
    eret = 1'b0;
    exp_rd("eret_mtc0_status", 5'd12, 32'h0040_0401);
    drain();

    // Hardware interrupt with one-cycle sampling latency.
    hw_int = 6'b000001;
    exp_port("hw_int_latency", 1, 32'h0);
    drain();
    tick();
    exp_rd("hw_int_cause", 5'd13, 32'h0000_0720);
    exp_port("hw_int_req", 1, 32'h1);
    drain();
    mtc0(5'd13, 32'h0);
    exp_rd("cause_cant_clr_hw", 5'd13, 32'h0000_0420);
    drain();

    // Reset mid-operation overrides strobes.
    reset = 1'b1; mtc0_en = 1'b1; mtc0_addr = 5'd12; mtc0_data = 32'hFFFF_FFFF;
    tick();
    reset = 1'b0; mtc0_en = 1'b0; hw_int = '0;
    exp_port("midrst_status", 3, 32'h0040_0000);
    exp_port("midrst_epc", 2, 32'h0);
    exp_port("midrst_cause", 4, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
